// File: rtl/charmquark1984_quad_decoder.sv
// charmquark1984_quad_decoder: synchronized quadrature decoder with wrapping position, sticky error and optional 7-seg output (QUAD_SEG7_EN)
module charmquark1984_quad_decoder #(
  parameter int POS_MAX = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] quad_in,
  input  logic       err_clr,
  output logic [3:0] pos,
  output logic       dir,
  output logic       step,
  output logic       err,
  output logic [6:0] seg
);
  localparam logic [3:0] PMAX = 4'(POS_MAX);
  logic [1:0] s1, s2, prev, ip, is;
  logic fwd, rev, bad;
  logic [3:0] pos_nxt;
  // Gray phase mapped to a 0..3 cycle index so direction is a +/-1 compare
  always_comb begin
    ip = {prev[1], ^prev};
    is = {s2[1], ^s2};
    fwd = is == 2'(ip + 2'd1);
    rev = ip == 2'(is + 2'd1);
    bad = (s2 ^ prev) == 2'b11;
    pos_nxt = fwd ? (pos == PMAX ? 4'd0 : pos + 4'd1) :
              rev ? (pos == 4'd0 ? PMAX : pos - 4'd1) : pos;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= quad_in;
      s2 <= quad_in;
      prev <= quad_in;
      pos <= 4'd0;
      dir <= 1'b1;
      step <= 1'b0;
      err <= 1'b0;
    end else begin
      s1 <= quad_in;
      s2 <= s1;
      prev <= s2;
      pos <= pos_nxt;
      dir <= fwd ? 1'b1 : rev ? 1'b0 : dir;
      step <= fwd | rev;
      err <= bad | (err & ~err_clr);
    end
  end
`ifdef QUAD_SEG7_EN
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: seg_of = 7'b0111111;
      4'd1: seg_of = 7'b0000110;
      4'd2: seg_of = 7'b1011011;
      4'd3: seg_of = 7'b1001111;
      4'd4: seg_of = 7'b1100110;
      4'd5: seg_of = 7'b1101101;
      4'd6: seg_of = 7'b1111101;
      4'd7: seg_of = 7'b0000111;
      4'd8: seg_of = 7'b1111111;
      4'd9: seg_of = 7'b1101111;
      default: seg_of = 7'b0000000;
    endcase
  endfunction
  // decode next position so seg changes in the same cycle as pos
  always_ff @(posedge clk) seg <= reset ? 7'b0111111 : seg_of(pos_nxt);
`else
  assign seg = 7'b0000000;
`endif
endmodule

// File: tb/tb_charmquark1984_quad_decoder.sv
// tb_charmquark1984_quad_decoder: directed self-checking bench for the quadrature decoder
module tb_charmquark1984_quad_decoder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] quad_in = 2'b00;
  logic err_clr = 1'b0;
  logic [3:0] pos;
  logic dir, step, err;
  logic [6:0] seg;
  int checks = 0;
  int errors = 0;
`ifdef QUAD_SEG7_EN
  localparam logic [6:0] SEG0 = 7'b0111111;
  localparam logic [6:0] SEG1 = 7'b0000110;
`else
  localparam logic [6:0] SEG0 = 7'b0000000;
  localparam logic [6:0] SEG1 = 7'b0000000;
`endif

  charmquark1984_quad_decoder #(.POS_MAX(9)) dut (
    .clk(clk), .reset(reset), .quad_in(quad_in), .err_clr(err_clr),
    .pos(pos), .dir(dir), .step(step), .err(err), .seg(seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // drive a phase just after an edge, hold 5 cycles; event expected right after the third edge
  task automatic phase(input logic [1:0] p, input logic exp_step, input logic [3:0] exp_pos);
    quad_in = p;
    tick(2);
    chk("step_early", 7'(step), 7'(1'b0));
    tick(1);
    chk("step_pulse", 7'(step), 7'(exp_step));
    tick(1);
    chk("step_end", 7'(step), 7'(1'b0));
    tick(1);
    chk("pos", 7'(pos), 7'(exp_pos));
  endtask

  initial begin
    reset = 1'b1;
    quad_in = 2'b11;
    tick(2);
    chk("rst_pos", 7'(pos), 7'd0);
    chk("rst_dir", 7'(dir), 7'd1);
    chk("rst_step", 7'(step), 7'd0);
    chk("rst_err", 7'(err), 7'd0);
    chk("rst_seg", seg, SEG0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("idle_step", 7'(step), 7'd0);
    end
    chk("idle_pos", 7'(pos), 7'd0);
    chk("idle_err", 7'(err), 7'd0);

    reset = 1'b1;
    quad_in = 2'b00;
    tick(1);
    reset = 1'b0;
    phase(2'b01, 1'b1, 4'd1);
    phase(2'b11, 1'b1, 4'd2);
    phase(2'b10, 1'b1, 4'd3);
    phase(2'b00, 1'b1, 4'd4);
    chk("fwd_dir", 7'(dir), 7'd1);

    phase(2'b01, 1'b1, 4'd5);
    phase(2'b11, 1'b1, 4'd6);
    phase(2'b10, 1'b1, 4'd7);
    phase(2'b00, 1'b1, 4'd8);
    phase(2'b01, 1'b1, 4'd9);
    phase(2'b11, 1'b1, 4'd0);
    phase(2'b01, 1'b1, 4'd9);
    chk("rev_dir", 7'(dir), 7'd0);
    phase(2'b00, 1'b1, 4'd8);
    chk("rev_dir2", 7'(dir), 7'd0);

    phase(2'b11, 1'b0, 4'd8);
    chk("ill_err", 7'(err), 7'd1);
    chk("ill_dir", 7'(dir), 7'd0);
    phase(2'b10, 1'b1, 4'd9);
    chk("resync_dir", 7'(dir), 7'd1);
    chk("err_sticky", 7'(err), 7'd1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr", 7'(err), 7'd0);
    quad_in = 2'b01;
    tick(2);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("set_wins", 7'(err), 7'd1);
    chk("set_wins_pos", 7'(pos), 7'd9);
    tick(2);

    quad_in = 2'b11;
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_pos", 7'(pos), 7'd0);
    chk("mid_rst_err", 7'(err), 7'd0);
    chk("mid_rst_seg", seg, SEG0);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("mid_rst_step", 7'(step), 7'd0);
    end
    chk("mid_rst_pos2", 7'(pos), 7'd0);
    phase(2'b10, 1'b1, 4'd1);
    chk("seg_one", seg, SEG1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/charmquark1984_quad_decoder.md
CHARMQUARK1984_QUAD_DECODER -- requirements
Module: charmquark1984_quad_decoder

Interface
REQ-001 Parameter: POS_MAX, 9, highest position value; legal range 1..15; position wraps 0..POS_MAX.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: quad_in  input  2  asynchronous 2-bit Gray phase from the upstream controller stage.
REQ-005 Port: err_clr  input  1  synchronous clear of the sticky error flag.
REQ-006 Port: pos  output  4  current position count, 0..POS_MAX.
REQ-007 Port: dir  output  1  direction of the last valid step; 1 = forward, 0 = reverse.
REQ-008 Port: step  output  1  one-cycle pulse on each valid step.
REQ-009 Port: err  output  1  sticky flag for an illegal transition.
REQ-010 Port: seg  output  7  seven-segment pattern of pos; bit0 = segment a … bit6 = segment g; active high.

Function
REQ-011 quad_in SHALL pass through a 2-flop synchronizer (s1, s2); the decoder SHALL compare s2 against a registered previous phase, prev, every cycle.
REQ-012 Forward transitions SHALL be 00->01, 01->11, 11->10 and 10->00; reverse transitions SHALL be their exact inverses.
REQ-013 s2 == prev SHALL produce no event: step = 0 and pos, dir and err unchanged.
REQ-014 A transition in which both bits change SHALL be illegal: err set to 1, step = 0, and pos and dir unchanged.
REQ-015 On a forward step, pos SHALL become 0 if pos == POS_MAX, else pos + 1; dir SHALL be set to 1.
REQ-016 On a reverse step, pos SHALL become POS_MAX if pos == 0, else pos - 1; dir SHALL be set to 0.
REQ-017 step SHALL be high for exactly one cycle per valid transition, registered together with the pos and dir update.
REQ-018 Latency: a quad_in change set up before edge E0 SHALL appear on pos, dir, step and err immediately after edge E2.
REQ-019 prev SHALL load s2 every cycle, including on illegal transitions, so decoding resynchronizes on the next phase.
REQ-020 err SHALL stay at 1 until err_clr is high on a rising edge; if err_clr and an illegal transition coincide, err SHALL remain 1 (set wins).
REQ-021 Consecutive valid transitions on consecutive cycles SHALL each produce a step pulse; step may therefore stay high across several cycles.

Reset
REQ-022 When reset is high on a rising edge, the block SHALL set pos = 0, dir = 1, step = 0 and err = 0.
REQ-023 When reset is high on a rising edge, s1, s2 and prev SHALL be loaded with the current quad_in.
REQ-024 For the first 2 cycles after reset deasserts (warm-up), prev SHALL track s2 and no step or err events SHALL be generated.
REQ-025 A reset asserted mid-operation SHALL discard any in-flight synchronizer transition; no step pulse SHALL appear in the cycle following reset.

Configuration
REQ-026 Macro QUAD_SEG7_EN defined: seg SHALL be a registered decode of pos, showing digits 0–9 in standard patterns, blank (0000000) for values 10–15, and 0111111 in reset.
REQ-027 Macro QUAD_SEG7_EN not defined: seg SHALL be constant 0000000, and no decoder or seg register SHALL be synthesized.

Verification
REQ-028 Reset with quad_in = 11, release, then hold quad_in = 11 for 10 cycles -> pos = 0, step never high, err = 0.
REQ-029 From pos = 0, drive forward sequence 00,01,11,10,00 with each phase held 5 cycles -> 4 step pulses, pos = 4, dir = 1, each pulse occurring 3 edges after its phase change.
REQ-030 With POS_MAX = 9 and pos = 9, apply one forward step -> pos = 0; then two reverse steps -> pos = 9, then 8, with dir = 0.
REQ-031 Jump quad_in 00 -> 11 -> err = 1, pos unchanged; then 11 -> 10 -> valid forward step; err_clr for 1 cycle -> err = 0; err_clr coinciding with an illegal jump -> err stays 1.
REQ-032 Assert reset for 1 cycle while a phase change is inside the synchronizer -> pos = 0, no step pulse afterwards; with QUAD_SEG7_EN defined, seg = 0111111, then seg = 0000110 after one forward step.
